ff_access_arbiter: RTL and testbench
====================================

Name: ff_access_arbiter

Overview:
Round-robin arbiter and sequencer that shares one synchronous 2-bit-input circuit (clk/reset/entrada[1:0] -> q) among NUM_REQ requesters. For each granted transaction it clears the shared circuit, forwards the winner's entrada for HOLD_CYCLES cycles, captures q, and returns the result tagged with the requester index. It sits between the requester blocks and the single shared flip-flop circuit instance.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..8.
HOLD_CYCLES, 4, cycles the winner's entrada drives the shared circuit; must be >= 1.
IDX_W, $clog2(NUM_REQ), derived localparam; width of index fields.

Ports:
clk  input  1  system clock; all state updates on rising edge.
reset  input  1  synchronous, active-high reset.
req  input  NUM_REQ  per-requester request level.
entrada_req  input  2*NUM_REQ  requester i's entrada in bits [2i+1:2i].
grant  output  NUM_REQ  one-hot; winner's bit high from CLEAR through CAPTURE.
ff_reset  output  1  reset to shared circuit; equals reset OR (state==CLEAR).
entrada_out  output  2  entrada to shared circuit.
q_in  input  1  q from shared circuit.
done  output  1  one-cycle pulse when the result is captured.
result_q  output  1  captured q; held until next done.
result_id  output  IDX_W  index of the requester served; held with result_q.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high. Port names are clk and reset.
- Reset values: state=IDLE, rr_ptr=0, grant=0, done=0, result_q=0, result_id=0, counter=0, entrada_out=00, ff_reset=1.
- FSM states: IDLE, CLEAR, RUN, CAPTURE.
- IDLE:
  - entrada_out=00, grant=0.
  - If any req bit is high, pick the first set bit at index >= rr_ptr, wrapping modulo NUM_REQ.
  - Register the winner's index as gidx, load counter=HOLD_CYCLES-1, go to CLEAR.
  - If no req bit is high, stay in IDLE.
- CLEAR (1 cycle): ff_reset=1, entrada_out=00, grant[gidx]=1.
- RUN (HOLD_CYCLES cycles):
  - entrada_out = entrada_req[2*gidx +: 2], combinational pass-through, so requesters may change it every cycle.
  - Counter decrements each cycle. When counter==0, go to CAPTURE.
- CAPTURE (1 cycle):
  - entrada_out=00.
  - The shared circuit is registered, so q_in now reflects the last RUN-cycle input.
  - On this edge: result_q<=q_in, result_id<=gidx, done<=1 (done is visible the following cycle).
  - rr_ptr <= (gidx+1) mod NUM_REQ. Go to IDLE.
- Transaction length: CLEAR + HOLD_CYCLES + CAPTURE cycles. Back-to-back grants are separated by 1 IDLE cycle.
- done is registered: high exactly one cycle, starting the cycle after CAPTURE.
- The req level is sampled only in IDLE. Deasserting req mid-transaction does not abort; the transaction completes and reports normally.
- Simultaneous requests are resolved only by rr_ptr. No requester waits more than NUM_REQ-1 transactions.
- Reset asserted in any state returns to IDLE on that edge. Any partial transaction is discarded: no done, and result_q/result_id are cleared. ff_reset stays high while reset is high.
- HOLD_CYCLES=1: RUN lasts exactly 1 cycle.

Decomposition:
- Package ff_arb_pkg holds:
  - arb_state_t enum {IDLE, CLEAR, RUN, CAPTURE};
  - localparam ENTRADA_W=2.
- One natural sub-module: rr_picker. It is purely combinational: (req, rr_ptr) -> (any, idx), with the wrap-around search. The top module holds the FSM, counter and output registers.

Test Plan:
Bench model of the shared circuit: q <= reset ? 0 : entrada[0]^entrada[1].
1. Single requester: req=0001, entrada_req[1:0]=01, HOLD=4 -> grant=0001 for 6 cycles; done after CAPTURE with result_q=1, result_id=0.
2. All requests: req=1111 held -> grant order 0,1,2,3,0; one transaction every 7 cycles; result_id sequence 0,1,2,3,0.
3. Wrap-around: req=1001 after serving requester 3 (rr_ptr=0) -> requester 0 granted next, then 3. With rr_ptr=2 and req=0011 -> requester 0 granted.
4. Reset mid-RUN: assert reset during the 2nd RUN cycle -> next cycle state=IDLE, grant=0, no done, result_q=0, ff_reset=1 while reset is high.
5. Requester drops req in CLEAR; entrada_req changes 11->10 during RUN -> transaction completes and done fires; result_q=1 (last RUN input 10).
6. HOLD_CYCLES=1 build, req=0100, entrada 11 -> grant lasts 3 cycles; result_q=0, result_id=2.

Source files
------------

// File: rtl/ff_arb_pkg.sv
// Shared types for the flip-flop access arbiter.
// States of the sequencer and the width of the shared circuit's input.
package ff_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CLEAR,
    RUN,
    CAPTURE
  } arb_state_t;

  localparam int ENTRADA_W = 2;

endpackage

// File: rtl/ff_access_arbiter_rr_picker.sv
// Round-robin picker: the first set request at or after rr_ptr,
// wrapping modulo NUM_REQ. Purely combinational.
module rr_picker
  import ff_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  int               j;
  logic [IDX_W-1:0] jj;

  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = 0;
    jj  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      jj = IDX_W'(j);
      if (!any && req[jj]) begin
        any = 1'b1;
        idx = jj;
      end
    end
  end

endmodule

// File: rtl/ff_access_arbiter.sv
// Shares one registered 2-bit-input circuit among NUM_REQ requesters:
// clear it, drive the winner's entrada, capture q, report result and id.
module ff_access_arbiter
  import ff_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int HOLD_CYCLES = 4,
  localparam int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [ENTRADA_W*NUM_REQ-1:0]   entrada_req,
  output logic [NUM_REQ-1:0]             grant,
  output logic                           ff_reset,
  output logic [ENTRADA_W-1:0]           entrada_out,
  input  logic                           q_in,
  output logic                           done,
  output logic                           result_q,
  output logic [IDX_W-1:0]               result_id
);

  localparam int CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  arb_state_t         state_q, state_d;
  logic [IDX_W-1:0]   gidx_q, gidx_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               done_q, done_d;
  logic               res_bit_q, res_bit_d;
  logic [IDX_W-1:0]   res_id_q, res_id_d;

  logic               pick_any;
  logic [IDX_W-1:0]   pick_idx;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req    (req),
    .rr_ptr (rr_ptr_q),
    .any    (pick_any),
    .idx    (pick_idx)
  );

  always_comb begin
    state_d   = state_q;
    gidx_d    = gidx_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    done_d    = 1'b0;
    res_bit_d = res_bit_q;
    res_id_d  = res_id_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = CLEAR;
          gidx_d  = pick_idx;
          cnt_d   = CNT_W'(HOLD_CYCLES - 1);
          grant_d = NUM_REQ'(1) << pick_idx;
        end
      end
      CLEAR: state_d = RUN;
      RUN: begin
        if (cnt_q == '0) state_d = CAPTURE;
        else cnt_d = cnt_q - CNT_W'(1);
      end
      CAPTURE: begin
        state_d   = IDLE;
        grant_d   = '0;
        done_d    = 1'b1;
        res_bit_d = q_in;
        res_id_d  = gidx_q;
        rr_ptr_d  = (gidx_q == IDX_W'(NUM_REQ - 1)) ?
                    '0 : gidx_q + IDX_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= 1'b0;
      res_bit_q <= 1'b0;
      res_id_q  <= '0;
    end else begin
      state_q   <= state_d;
      gidx_q    <= gidx_d;
      rr_ptr_q  <= rr_ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      res_bit_q <= res_bit_d;
      res_id_q  <= res_id_d;
    end
  end

  // Live pass-through so requesters can vary entrada every RUN cycle.
  always_comb begin
    entrada_out = '0;
    if (state_q == RUN)
      entrada_out = entrada_req[ENTRADA_W*gidx_q +: ENTRADA_W];
  end

  assign ff_reset  = reset | (state_q == CLEAR);
  assign grant     = grant_q;
  assign done      = done_q;
  assign result_q  = res_bit_q;
  assign result_id = res_id_q;

endmodule

// File: tb/tb_ff_access_arbiter.sv
// Directed bench for ff_access_arbiter, with a model of the shared
// circuit (q <= reset ? 0 : e[0]^e[1]) behind each instance.
module tb_ff_access_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;

  logic [3:0] req0 = '0, grant0;
  logic [7:0] er0 = '0;
  logic [1:0] eo0, rid0;
  logic       ffr0, q0 = 1'b0, done0, rq0;

  logic [3:0] req1 = '0, grant1;
  logic [7:0] er1 = '0;
  logic [1:0] eo1, rid1;
  logic       ffr1, q1 = 1'b0, done1, rq1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) q0 <= ffr0 ? 1'b0 : (eo0[0] ^ eo0[1]);
  always @(posedge clk) q1 <= ffr1 ? 1'b0 : (eo1[0] ^ eo1[1]);

  ff_access_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(4)) u_dut0 (
    .clk         (clk),
    .reset       (reset),
    .req         (req0),
    .entrada_req (er0),
    .grant       (grant0),
    .ff_reset    (ffr0),
    .entrada_out (eo0),
    .q_in        (q0),
    .done        (done0),
    .result_q    (rq0),
    .result_id   (rid0)
  );

  ff_access_arbiter #(.NUM_REQ(4), .HOLD_CYCLES(1)) u_dut1 (
    .clk         (clk),
    .reset       (reset),
    .req         (req1),
    .entrada_req (er1),
    .grant       (grant1),
    .ff_reset    (ffr1),
    .entrada_out (eo1),
    .q_in        (q1),
    .done        (done1),
    .result_q    (rq1),
    .result_id   (rid1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    tests++;
    if (grant0 !== 4'b0 || done0 !== 1'b0 || rq0 !== 1'b0 ||
        rid0 !== 2'd0 || ffr0 !== 1'b1 || eo0 !== 2'b00) begin
      fails++;
      $display("FAIL reset_state: grant=%b done=%b rq=%b id=%0d ffr=%b eo=%b, need 0000 0 0 0 1 00",
               grant0, done0, rq0, rid0, ffr0, eo0);
    end
    reset = 1'b0;
    tick;
    tests++;
    if (ffr0 !== 1'b0 || grant0 !== 4'b0) begin
      fails++;
      $display("FAIL reset_release: ffr=%b grant=%b, need 0 0000", ffr0, grant0);
    end
  endtask

  task automatic test_single;
    int  gcnt;
    bit  got;
    req0 = 4'b0001;
    er0  = 8'h01;
    tick;
    tests++;
    if (grant0 !== 4'b0001 || ffr0 !== 1'b1 || eo0 !== 2'b00) begin
      fails++;
      $display("FAIL single_clear: grant=%b ffr=%b eo=%b, need 0001 1 00", grant0, ffr0, eo0);
    end
    req0 = 4'b0;
    gcnt = 1;
    got  = 0;
    tick;
    tests++;
    if (eo0 !== 2'b01) begin
      fails++;
      $display("FAIL single_run_entrada: eo=%b, need 01", eo0);
    end
    if (grant0 != 0) gcnt++;
    for (int c = 0; c < 20 && !got; c++) begin
      tick;
      if (done0) got = 1;
      else if (grant0 != 0) gcnt++;
    end
    tests++;
    if (!got || gcnt != 6) begin
      fails++;
      $display("FAIL single_grant_len: done_seen=%0d grant_cycles=%0d, need 1 6", got, gcnt);
    end
    tests++;
    if (rq0 !== 1'b1 || rid0 !== 2'd0 || grant0 !== 4'b0) begin
      fails++;
      $display("FAIL single_result: rq=%b id=%0d grant=%b, need 1 0 0000", rq0, rid0, grant0);
    end
    tick;
    tests++;
    if (done0 !== 1'b0 || rq0 !== 1'b1) begin
      fails++;
      $display("FAIL single_done_pulse: done=%b rq=%b, need 0 1", done0, rq0);
    end
  endtask

  task automatic test_all_requests;
    logic [1:0] exp_id;
    logic       exp_q;
    int         prev;
    bit         got;
    logic [4:0] qs;
    qs = 5'b10101;
    prev = 0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    er0  = 8'h2D;
    req0 = 4'hF;
    for (int n = 0; n < 5; n++) begin
      exp_id = 2'(n % 4);
      exp_q  = qs[n];
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        tick;
        if (done0) got = 1;
      end
      if (n == 4) req0 = 4'b0;
      tests++;
      if (!got || rid0 !== exp_id || rq0 !== exp_q) begin
        fails++;
        $display("FAIL all_req_%0d: done_seen=%0d id=%0d q=%b, need 1 %0d %b",
                 n, got, rid0, rq0, exp_id, exp_q);
      end
      if (n > 0) begin
        tests++;
        if (cyc - prev != 7) begin
          fails++;
          $display("FAIL all_req_period_%0d: %0d cycles, need 7", n, cyc - prev);
        end
      end
      prev = cyc;
    end
  endtask

  task automatic test_wrap;
    logic [3:0] reqs [5];
    logic [1:0] ids  [5];
    logic       qv   [5];
    bit         got;
    reqs = '{4'b1000, 4'b1001, 4'b1001, 4'b0010, 4'b0011};
    ids  = '{2'd3, 2'd0, 2'd3, 2'd1, 2'd0};
    qv   = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int n = 0; n < 5; n++) begin
      req0 = reqs[n];
      got = 0;
      for (int c = 0; c < 20 && !got; c++) begin
        tick;
        if (done0) got = 1;
      end
      req0 = 4'b0;
      tests++;
      if (!got || rid0 !== ids[n] || rq0 !== qv[n]) begin
        fails++;
        $display("FAIL wrap_%0d: done_seen=%0d id=%0d q=%b, need 1 %0d %b",
                 n, got, rid0, rq0, ids[n], qv[n]);
      end
    end
  endtask

  task automatic test_reset_mid_run;
    int dcnt;
    req0 = 4'b0010;
    tick;
    req0 = 4'b0;
    tick;
    tick;
    reset = 1'b1;
    #1;
    tests++;
    if (ffr0 !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_ffreset: ffr=%b, need 1", ffr0);
    end
    tick;
    tests++;
    if (grant0 !== 4'b0 || done0 !== 1'b0 || rq0 !== 1'b0 ||
        rid0 !== 2'd0 || ffr0 !== 1'b1 || eo0 !== 2'b00) begin
      fails++;
      $display("FAIL rst_mid_state: grant=%b done=%b rq=%b id=%0d ffr=%b eo=%b, need 0000 0 0 0 1 00",
               grant0, done0, rq0, rid0, ffr0, eo0);
    end
    tick;
    reset = 1'b0;
    dcnt = 0;
    for (int c = 0; c < 10; c++) begin
      tick;
      if (done0 || grant0 != 0) dcnt++;
    end
    tests++;
    if (dcnt != 0) begin
      fails++;
      $display("FAIL rst_mid_no_done: %0d active cycles, need 0", dcnt);
    end
  endtask

  task automatic test_drop_and_change;
    bit got;
    er0  = 8'h03;
    req0 = 4'b0001;
    tick;
    req0 = 4'b0;
    tick;
    tests++;
    if (eo0 !== 2'b11) begin
      fails++;
      $display("FAIL drop_run1_entrada: eo=%b, need 11", eo0);
    end
    tick;
    tick;
    er0 = 8'h02;
    #1;
    tests++;
    if (eo0 !== 2'b10) begin
      fails++;
      $display("FAIL drop_passthrough: eo=%b, need 10", eo0);
    end
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick;
      if (done0) got = 1;
    end
    tests++;
    if (!got || rq0 !== 1'b1 || rid0 !== 2'd0) begin
      fails++;
      $display("FAIL drop_result: done_seen=%0d q=%b id=%0d, need 1 1 0", got, rq0, rid0);
    end
  endtask

  task automatic test_hold1;
    int gcnt;
    bit got;
    bit bad;
    er1  = 8'h30;
    req1 = 4'b0100;
    gcnt = 0;
    got  = 0;
    bad  = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      tick;
      req1 = 4'b0;
      if (done1) got = 1;
      else if (grant1 != 0) begin
        gcnt++;
        if (grant1 !== 4'b0100) bad = 1;
      end
    end
    tests++;
    if (!got || gcnt != 3 || bad) begin
      fails++;
      $display("FAIL hold1_grant: done_seen=%0d grant_cycles=%0d wrong_bit=%0d, need 1 3 0",
               got, gcnt, bad);
    end
    tests++;
    if (rq1 !== 1'b0 || rid1 !== 2'd2) begin
      fails++;
      $display("FAIL hold1_result: q=%b id=%0d, need 0 2", rq1, rid1);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_all_requests;
    test_wrap;
    test_reset_mid_run;
    test_drop_and_change;
    test_hold1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
